lh_digest_hex_serializer: RTL

- Downstream stage of the light-hash core.
- Captures each 64-bit digest when the hash core asserts its digest-ready pulse.
- Emits the digest as 16 ASCII hexadecimal characters, most-significant nibble first, optionally followed by a newline.
- Uses a valid/ready byte handshake, so results can go to a file writer, UART or bench monitor under backpressure.

---
 rtl/lh_digest_hex_serializer.sv | 73 +++++++
 1 files changed

// File: rtl/lh_digest_hex_serializer.sv
// lh_digest_hex_serializer: streams each captured 64-bit digest as 16 ASCII hex chars (MSB nibble first) plus an optional newline over valid/ready.
// Ports: clk; rst_n (sync, active-high reset); digest_in/digest_valid capture pulse;
//        out_char/out_valid/out_ready byte stream; busy while sending; done/overflow one-cycle pulses.
module lh_digest_hex_serializer #(
  parameter int UPPERCASE = 0,
  parameter int APPEND_NL = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] digest_in,
  input  logic        digest_valid,
  output logic [7:0]  out_char,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic        overflow
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] TERM = 2'd2;
  logic [1:0]  r_state;
  logic [63:0] r_sh;
  logic [3:0]  r_cnt;
  logic [7:0]  r_char;
  logic        r_done;
  logic        r_ovf;
  logic        w_hs;
  logic        w_complete;
  logic        w_cap;
  function automatic logic [7:0] hex(input logic [3:0] n);
    return n < 4'd10 ? 8'h30 + {4'h0, n} : (UPPERCASE != 0 ? 8'h37 : 8'h57) + {4'h0, n};
  endfunction
  assign out_valid  = r_state != IDLE;
  assign busy       = r_state != IDLE;
  assign out_char   = r_char;
  assign done       = r_done;
  assign overflow   = r_ovf;
  assign w_hs       = out_valid && out_ready;
  assign w_complete = w_hs && (r_state == TERM || (r_state == SEND && r_cnt == 4'hf && APPEND_NL == 0));
  // A digest arriving on the completing handshake is taken back-to-back instead of being dropped.
  assign w_cap      = digest_valid && (r_state == IDLE || w_complete);
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state <= IDLE;
      r_sh    <= '0;
      r_cnt   <= '0;
      r_char  <= '0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= w_complete;
      r_ovf  <= digest_valid && !w_cap;
      if (w_cap) begin
        r_state <= SEND;
        r_sh    <= digest_in;
        r_cnt   <= '0;
        r_char  <= hex(digest_in[63:60]);
      end else if (w_complete) begin
        r_state <= IDLE;
      end else if (w_hs && r_state == SEND) begin
        if (r_cnt == 4'hf) begin
          r_state <= TERM;
          r_char  <= 8'h0a;
        end else begin
          r_sh   <= r_sh << 4;
          r_cnt  <= r_cnt + 4'd1;
          r_char <= hex(r_sh[59:56]);
        end
      end
    end
  end
endmodule
